flash_burst_reader: RTL and testbench

//  Command-driven read sequencer for the flashLoader memory port (avl_mem_*).
//  It copies a word-addressed block of flash into a 32-bit valid/ready stream,
//  e.g. for sprite or palette load into GPU RAM.
//  It splits the block into Avalon bursts and gates each burst on free FIFO space.
//  It is the only master on avl_mem; the CSR port is configured elsewhere.

---
 rtl/flash_burst_reader.sv | 193 +++++++++++++++++++
 tb/tb_flash_burst_reader.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_reader.sv
// flash_burst_reader
//   Copies a word-addressed block of flash (avl_mem port) into a 32-bit
//   valid/ready stream. The block is split into Avalon read bursts of at most
//   BURST_MAX beats. A burst is only issued once the output FIFO has room for
//   the whole burst, so the FIFO can never overflow. Only one burst is
//   outstanding at a time.
//
// Ports
//   clk_clk, reset_reset        clock, asynchronous active-high reset
//   cmd_start/src_addr/len      job request (start sampled only when idle)
//   cmd_abort                   stop the job early (sticky while busy)
//   cmd_busy/done/aborted       job status; done is a 1-cycle pulse
//   avm_*                       Avalon-MM burst read master
//   out_data/valid/ready        output word stream
module flash_burst_reader #(
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned BURST_MAX  = 64,
  parameter int unsigned FIFO_DEPTH = 128
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_start,
  input  logic [ADDR_W-1:0] cmd_src_addr,
  input  logic [15:0]       cmd_len,
  input  logic              cmd_abort,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic              cmd_aborted,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic [6:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StBeats, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       remaining_q;
  logic [6:0]        blen_q;
  logic [6:0]        beat_cnt_q;
  logic              abort_q;
  logic              pend_q;

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  logic [6:0]        blen;
  logic [31:0]       fifo_free;
  logic              busy_state;
  logic              accept;
  logic              beat;
  logic              last_beat;
  logic              push;
  logic              pop;
  logic              flush;

  // Length of the next burst: whole bursts first, the remainder last.
  assign blen       = (remaining_q >= 16'(BURST_MAX)) ? 7'(BURST_MAX) : remaining_q[6:0];
  // No burst is in flight while issuing, so free space is simply depth minus held words.
  assign fifo_free  = 32'(FIFO_DEPTH) - 32'(count_q);
  assign busy_state = (state_q == StIssue) || (state_q == StBeats) || (state_q == StDrain);
  assign accept     = avm_read & ~avm_waitrequest;
  assign beat       = (state_q == StBeats) & avm_readdatavalid;
  assign last_beat  = beat && ((beat_cnt_q + 7'd1) == blen_q);
  // Beats that arrive after an abort are absorbed but not stored.
  assign push       = beat & ~abort_q;
  assign pop        = out_valid & out_ready;
  assign flush      = (state_q == StDrain) & abort_q;

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (cmd_start) state_d = (cmd_len == 16'd0) ? StDone : StIssue;
      end
      StIssue: begin
        if (accept) begin
          state_d = StBeats;
        end else if (abort_q && !pend_q) begin
          state_d = StDrain;
        end
      end
      StBeats: begin
        if (last_beat) begin
          // An abort arriving with the last beat still ends the job as an abort.
          state_d = (abort_q || cmd_abort || remaining_q == 16'd0) ? StDrain : StIssue;
        end
      end
      StDrain: begin
        if (abort_q || count_q == '0) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    cmd_busy    = busy_state;
    cmd_done    = (state_q == StDone);
    cmd_aborted = (state_q == StDone) & abort_q;
    // Once a read has been presented under waitrequest it must stay up until
    // accepted, even if an abort arrives meanwhile.
    avm_read    = (state_q == StIssue) &&
                  (pend_q || (!abort_q && fifo_free >= 32'(blen)));
    avm_burstcount = avm_read ? blen : 7'd0;
    avm_address    = addr_q;
  end

  // Job datapath
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      blen_q      <= '0;
      beat_cnt_q  <= '0;
      abort_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      pend_q <= (state_q == StIssue) & avm_read & avm_waitrequest;
      if (state_q == StIdle && cmd_start) begin
        addr_q      <= cmd_src_addr;
        remaining_q <= cmd_len;
        abort_q     <= 1'b0;
      end else if (busy_state && cmd_abort) begin
        abort_q <= 1'b1;
      end
      if (accept) begin
        addr_q      <= addr_q + ADDR_W'(blen);
        remaining_q <= remaining_q - 16'(blen);
        blen_q      <= blen;
        beat_cnt_q  <= '0;
      end else if (beat) begin
        beat_cnt_q <= beat_cnt_q + 7'd1;
      end
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= avm_readdata;
  end

  // Output FIFO pointers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : 32'd0;

  // Space reservation must make overflow impossible.
  fifo_no_overflow: assert property (@(posedge clk_clk) disable iff (reset_reset)
    push |-> (count_q != CW'(FIFO_DEPTH) || pop));

endmodule

// File: tb/tb_flash_burst_reader.sv
module tb_flash_burst_reader;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned AMASK  = (1 << ADDR_W) - 1;

  logic              clk;
  logic              rst;
  logic              cmd_start;
  logic [ADDR_W-1:0] cmd_src_addr;
  logic [15:0]       cmd_len;
  logic              cmd_abort;
  logic              cmd_busy;
  logic              cmd_done;
  logic              cmd_aborted;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic [6:0]        avm_burstcount;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic [31:0]       out_data;
  logic              out_valid;
  logic              out_ready;

  flash_burst_reader #(
    .ADDR_W    (21),
    .BURST_MAX (64),
    .FIFO_DEPTH(128)
  ) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .cmd_start        (cmd_start),
    .cmd_src_addr     (cmd_src_addr),
    .cmd_len          (cmd_len),
    .cmd_abort        (cmd_abort),
    .cmd_busy         (cmd_busy),
    .cmd_done         (cmd_done),
    .cmd_aborted      (cmd_aborted),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected stream words and expected bursts of the current job.
  logic [31:0] exp_words[$];
  int unsigned exp_baddr[$];
  int unsigned exp_bcnt[$];
  int unsigned beat_q[$];

  // Slave / sink behaviour knobs and observations.
  int  ready_mode;      // 0 low, 1 high, 2 random
  int  wr_mode;         // 0 never, 1 random waitrequest
  int  gap_mode;        // 0 back-to-back beats, 1 random gaps
  int  wr_hold;         // forced waitrequest cycles on the next read
  int  abort_at_beat;   // fire cmd_abort on this beat of the first burst
  int  accepts_in_job;
  int  beat_in_burst;
  int  stall_cnt;
  int  done_cnt;
  bit  exp_aborted;
  bit  no_read_allowed;
  bit  read_seen;
  bit  prev_wait;
  logic [ADDR_W-1:0] prev_addr;
  logic [6:0]        prev_cnt;
  int unsigned       cur_a;

  function automatic logic [31:0] mem_word(input logic [20:0] a);
    return {a[10:0], a} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  // Reference model: the words and bursts a job must produce.
  task automatic model_job(input int unsigned addr, input int unsigned len);
    int unsigned rem;
    int unsigned a;
    int unsigned c;
    for (int unsigned i = 0; i < len; i++) exp_words.push_back(mem_word(21'((addr + i) & AMASK)));
    rem = len;
    a   = addr & AMASK;
    while (rem > 0) begin
      c = (rem > 64) ? 64 : rem;
      exp_baddr.push_back(a);
      exp_bcnt.push_back(c);
      a   = (a + c) & AMASK;
      rem = rem - c;
    end
  endtask

  // Avalon slave, stream sink and monitor; all sampled/driven mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      cmd_abort         = 1'b0;
      prev_wait         = 1'b0;
    end else begin
      cmd_abort = 1'b0;
      if (beat_q.size() > 0 && (gap_mode == 0 || $urandom_range(3) != 0)) begin
        cur_a             = beat_q.pop_front();
        avm_readdata      = mem_word(21'(cur_a));
        avm_readdatavalid = 1'b1;
        beat_in_burst++;
        if (abort_at_beat > 0 && accepts_in_job == 1 && beat_in_burst == abort_at_beat) begin
          cmd_abort       = 1'b1;
          abort_at_beat   = 0;
          no_read_allowed = 1'b1;
        end
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end

      out_ready = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);

      if (prev_wait) begin
        check("read held under waitrequest", 64'(avm_read), 64'd1);
        check("address held under waitrequest", 64'(avm_address), 64'(prev_addr));
        check("burstcount held under waitrequest", 64'(avm_burstcount), 64'(prev_cnt));
      end

      if (avm_read) begin
        read_seen = 1'b1;
        if (wr_hold > 0) begin
          avm_waitrequest = 1'b1;
          wr_hold--;
        end else begin
          avm_waitrequest = (wr_mode == 1) && ($urandom_range(3) == 0);
        end
      end else begin
        avm_waitrequest = (wr_mode == 1) && ($urandom_range(1) == 0);
      end
      prev_wait = avm_read & avm_waitrequest;
      prev_addr = avm_address;
      prev_cnt  = avm_burstcount;
      if (prev_wait) stall_cnt++;

      if (avm_read && !avm_waitrequest) begin
        accepts_in_job++;
        beat_in_burst = 0;
        if (no_read_allowed) note_fail("read after abort");
        if (exp_baddr.size() == 0) begin
          note_fail("unexpected burst");
        end else begin
          check("burst address", 64'(avm_address), 64'(exp_baddr.pop_front()));
          check("burstcount", 64'(avm_burstcount), 64'(exp_bcnt.pop_front()));
        end
        for (int unsigned i = 0; i < avm_burstcount; i++)
          beat_q.push_back((avm_address + i) & AMASK);
      end

      if (out_valid && out_ready) begin
        if (exp_words.size() == 0) note_fail("unexpected output word");
        else check("out_data", 64'(out_data), 64'(exp_words.pop_front()));
      end

      if (cmd_done) begin
        done_cnt++;
        check("cmd_aborted", 64'(cmd_aborted), 64'(exp_aborted));
        if (!exp_aborted) begin
          check("words outstanding at done", 64'(exp_words.size()), 64'd0);
          check("bursts outstanding at done", 64'(exp_baddr.size()), 64'd0);
        end else begin
          check("beats absorbed before done", 64'(beat_q.size()), 64'd0);
          exp_words.delete();
          exp_baddr.delete();
          exp_bcnt.delete();
        end
      end
    end
  end

  task automatic start_job(input int unsigned addr, input int unsigned len, input bit abort);
    @(negedge clk);
    exp_aborted    = abort;
    accepts_in_job = 0;
    beat_in_burst  = 0;
    stall_cnt      = 0;
    read_seen      = 1'b0;
    model_job(addr, len);
    cmd_src_addr = 21'(addr);
    cmd_len      = 16'(len);
    cmd_start    = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    if (len > 0) check("busy after start", 64'(cmd_busy), 64'd1);
    else         check("done one cycle after zero-length start", 64'(cmd_done), 64'd1);
  endtask

  task automatic wait_done(input int limit);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == start_cnt) note_fail("done timeout");
  endtask

  function automatic logic [63:0] all_outputs();
    return {cmd_busy, cmd_done, cmd_aborted, avm_read, avm_burstcount, out_valid,
            avm_address[20:0], out_data[0]} | 64'(out_data != 32'd0);
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    cmd_start = 1'b0; cmd_src_addr = '0; cmd_len = '0; cmd_abort = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; out_ready = 1'b0;
    ready_mode = 1; wr_mode = 0; gap_mode = 0; wr_hold = 0; abort_at_beat = 0;
    accepts_in_job = 0; beat_in_burst = 0; stall_cnt = 0; done_cnt = 0;
    exp_aborted = 1'b0; no_read_allowed = 1'b0; read_seen = 1'b0; prev_wait = 1'b0;
    repeat (3) @(negedge clk);
    check("outputs in reset", all_outputs(), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single short burst; first read must appear the cycle after start.
    start_job(32'h100, 5, 1'b0);
    check("first read one cycle after start", 64'(avm_read), 64'd1);
    wait_done(500);

    // Three bursts 64/64/22 under random ready, beat gaps and waitrequest.
    ready_mode = 2; gap_mode = 1; wr_mode = 1;
    start_job(32'h1234, 150, 1'b0);
    wait_done(5000);
    check("bursts for len 150", 64'(accepts_in_job), 64'd3);

    // Seven forced waitrequest cycles on the first read.
    ready_mode = 1; gap_mode = 0; wr_mode = 0; wr_hold = 7;
    start_job(32'h2000, 64, 1'b0);
    wait_done(500);
    check("stall cycles on first read", 64'(stall_cnt), 64'd7);
    check("single accept", 64'(accepts_in_job), 64'd1);

    // Back-pressure: FIFO fills with two bursts, then issue stops.
    ready_mode = 0;
    start_job(32'h3000, 200, 1'b0);
    repeat (300) @(negedge clk);
    check("bursts while blocked", 64'(accepts_in_job), 64'd2);
    check("read low while FIFO full", 64'(avm_read), 64'd0);
    check("valid while blocked", 64'(out_valid), 64'd1);
    ready_mode = 1;
    wait_done(2000);
    check("bursts for len 200", 64'(accepts_in_job), 64'd4);

    // Abort on beat 10 of the first 64-beat burst.
    ready_mode = 1; abort_at_beat = 10;
    start_job(32'h4000, 150, 1'b1);
    wait_done(1000);
    @(negedge clk);
    check("FIFO flushed after abort", 64'(out_valid), 64'd0);
    check("bursts in aborted job", 64'(accepts_in_job), 64'd1);
    check("busy low after abort", 64'(cmd_busy), 64'd0);
    no_read_allowed = 1'b0;

    // Zero-length job.
    start_job(32'h5000, 0, 1'b0);
    repeat (10) @(negedge clk);
    check("no read on zero-length job", 64'(read_seen), 64'd0);

    // Asynchronous reset in the middle of a burst.
    start_job(32'h6000, 150, 1'b0);
    n = 0;
    while (beat_in_burst < 20 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (beat_in_burst < 20) note_fail("beat wait timeout");
    #2 rst = 1'b1;
    #1 check("outputs right after async reset", all_outputs(), 64'd0);
    exp_words.delete();
    exp_baddr.delete();
    exp_bcnt.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("late beats ignored", 64'(out_valid), 64'd0);
    check("idle after reset", 64'(cmd_busy), 64'd0);
    check("late beats delivered", 64'(beat_q.size()), 64'd0);

    // Randomised jobs, including an address wrap at the top of the space.
    for (int j = 0; j < 6; j++) begin
      int unsigned a;
      int unsigned l;
      ready_mode = $urandom_range(1, 2);
      gap_mode   = $urandom_range(0, 1);
      wr_mode    = $urandom_range(0, 1);
      a = (j == 0) ? 32'h1F_FFF0 : ($urandom & AMASK);
      l = (j == 0) ? 100 : $urandom_range(0, 260);
      start_job(a, l, 1'b0);
      wait_done(6000);
      repeat (3) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
